// File: rtl/dsp_sample_capture.sv
// rtl/dsp_sample_capture.sv - triggered circular capture buffer with oldest-first readback
module dsp_sample_capture #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int PRE_TRIG   = 64
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic signed [DATA_W-1:0]     sample_in,
  input  logic                         sample_ce,
  input  logic                         arm,
  input  logic                         force_trig,
  input  logic signed [DATA_W-1:0]     trig_level,
  input  logic                         trig_fall,
  input  logic                         rd_req,
  input  logic        [DEPTH_LOG2-1:0] rd_addr,
  output logic signed [DATA_W-1:0]     rd_data,
  output logic                         rd_valid,
  output logic        [2:0]            state,
  output logic                         done,
  output logic        [DEPTH_LOG2-1:0] trig_ptr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  // Sample counts that end the FILL and POST phases; the trigger sample is counted in POST.
  localparam logic [CW-1:0]         PRE_CNT  = CW'(PRE_TRIG);
  localparam logic [CW-1:0]         POST_CNT = CW'(DEPTH - PRE_TRIG);
  localparam logic [DEPTH_LOG2-1:0] PRE_OFF  = DEPTH_LOG2'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [DEPTH_LOG2-1:0]    wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0]    trig_ptr_q, trig_ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            cnt_inc;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic                     force_q, force_d;
  logic                     done_q, done_d;
  logic signed [DATA_W-1:0] rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;

  logic                     accept;
  logic                     cross_rise;
  logic                     cross_fall;
  logic                     trig_hit;
  logic [DEPTH_LOG2-1:0]    rd_phys;

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Sample acceptance, level-crossing detection and logical-to-physical read address.
  always_comb begin
    accept     = sample_ce && ((state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST));
    cross_rise = (prev_q < trig_level) && (sample_in >= trig_level);
    cross_fall = (prev_q > trig_level) && (sample_in <= trig_level);
    trig_hit   = force_q || (trig_fall ? cross_fall : cross_rise);
    cnt_inc    = cnt_q + 1'b1;
    rd_phys    = trig_ptr_q - PRE_OFF + rd_addr;
  end

  // Capture FSM: next state, counters, trigger pointer and write pointer.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    trig_ptr_d = trig_ptr_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    force_d    = force_q;
    done_d     = done_q;

    if (accept) begin
      wptr_d = wptr_q + 1'b1;
      prev_d = sample_in;
    end

    if ((state_q == S_ARMED) && force_trig) begin
      force_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
      end
      S_FILL: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == PRE_CNT) begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (accept && trig_hit) begin
          trig_ptr_d = wptr_q;
          cnt_d      = {{(CW-1){1'b0}}, 1'b1};
          force_d    = 1'b0;
          if (POST_CNT == {{(CW-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == POST_CNT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A restart overrides whatever the current capture was doing; a coincident sample
    // has already been written into the aborted capture above.
    if (arm) begin
      state_d = S_FILL;
      cnt_d   = '0;
      done_d  = 1'b0;
      force_d = 1'b0;
    end
  end

  // Registered read port: old data wins on a same-address write, data holds when idle.
  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_req ? mem[rd_phys] : rd_data_q;
  end

  // Control and readback registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      trig_ptr_q <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      force_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      trig_ptr_q <= trig_ptr_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      force_q    <= force_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Sample RAM, never cleared; written on every accepted sample.
  always_ff @(posedge sys_clk) begin
    if (!reset && accept) begin
      mem[wptr_q] <= sample_in;
    end
  end

  assign state    = state_q;
  assign done     = done_q;
  assign trig_ptr = trig_ptr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_dsp_sample_capture.sv
// tb/tb_dsp_sample_capture.sv - scoreboard bench for dsp_sample_capture
module tb_dsp_sample_capture;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  logic                 sys_clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] sample_in;
  logic                 sample_ce;
  logic                 arm;
  logic                 force_trig;
  logic signed [DW-1:0] trig_level;
  logic                 trig_fall;
  logic                 rd_req;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;
  logic                 rd_valid;
  logic [2:0]           state;
  logic                 done;
  logic [AW-1:0]        trig_ptr;

  int checks = 0;
  int errors = 0;
  logic signed [DW-1:0] exp_q[$];
  logic exp_valid = 1'b0;
  int hist[$];

  always #5 sys_clk = ~sys_clk;

  dsp_sample_capture #(.DATA_W(DW), .DEPTH_LOG2(AW), .PRE_TRIG(PRE)) dut (
    .sys_clk(sys_clk), .reset(reset), .sample_in(sample_in), .sample_ce(sample_ce),
    .arm(arm), .force_trig(force_trig), .trig_level(trig_level), .trig_fall(trig_fall),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .state(state), .done(done), .trig_ptr(trig_ptr)
  );

  // Expected read-valid: the request one cycle later, dropped by reset.
  always @(posedge sys_clk) exp_valid <= rd_req && !reset;

  // Monitor: checks read timing every cycle and pops the scoreboard on each valid beat.
  always @(negedge sys_clk) begin
    logic signed [DW-1:0] e;
    checks++;
    if (rd_valid !== exp_valid) begin
      errors++;
      $display("FAIL rd_valid_timing: got %b expected %b at %0t", rd_valid, exp_valid, $time);
    end
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data_unexpected: got %0d expected no data", rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0d expected %0d", rd_data, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic send(input int v, input int gap);
    sample_in = DW'(v);
    sample_ce = 1'b1;
    hist.push_back(v);
    tick();
    sample_ce = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    hist.delete();
  endtask

  task automatic readout(input int trig_idx);
    for (int a = 0; a < DEPTH; a++) begin
      rd_req  = 1'b1;
      rd_addr = AW'(a);
      exp_q.push_back(DW'(hist[trig_idx - PRE + a]));
      tick();
    end
    rd_req = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("readout_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; sample_in = '0; sample_ce = 1'b0; arm = 1'b0; force_trig = 1'b0;
    trig_level = '0; trig_fall = 1'b0; rd_req = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("reset_state", state, 0);
    check("reset_done", done, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_trig_ptr", trig_ptr, 0);
    reset = 1'b0;
    tick();

    // Rising trigger at level 0, ramp k-20 every 4th cycle, starting at wptr 0.
    do_arm();
    check("t1_fill", state, 1);
    for (int k = 0; k < 31; k++) begin
      send(k - 20, 3);
      if (k == 3)  check("t1_armed", state, 2);
      if (k == 19) check("t1_not_trig", state, 2);
      if (k == 20) begin
        check("t1_post", state, 3);
        check("t1_trig_ptr", trig_ptr, 4);
      end
    end
    check("t1_done_early", done, 0);
    send(11, 3);
    check("t1_done", done, 1);
    check("t1_state_done", state, 4);
    for (int k = 0; k < 3; k++) send(999, 0);
    check("t1_done_hold", state, 4);
    readout(20);

    // Level never crossed; force_trig makes the next sample the trigger.
    trig_level = 16'sd32767;
    do_arm();
    for (int k = 0; k < 10; k++) send(k - 20, 3);
    check("t2_armed", state, 2);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    check("t2_still_armed", state, 2);
    send(-10, 3);
    check("t2_post", state, 3);
    check("t2_trig_ptr", trig_ptr, 10);
    for (int k = 11; k < 21; k++) send(k - 20, 3);
    check("t2_done_early", done, 0);
    send(1, 3);
    check("t2_done", done, 1);
    readout(10);

    // Falling trigger at level 0 on descending ramp; wptr starts at 6.
    trig_level = '0;
    trig_fall  = 1'b1;
    do_arm();
    for (int k = 0; k < 31; k++) send(20 - k, 1);
    check("t3_trig_ptr", trig_ptr, 10);
    check("t3_done_early", done, 0);
    send(-11, 1);
    check("t3_done", done, 1);
    readout(20);

    // Restart in the middle of POST; readout must reflect only the new capture.
    trig_fall = 1'b0;
    do_arm();
    for (int k = 0; k < 25; k++) send(k - 20, 1);
    check("t4_in_post", state, 3);
    do_arm();
    check("t4_refill", state, 1);
    check("t4_done_clear", done, 0);
    for (int k = 0; k < 21; k++) send(2 * (k - 10) + 1, 1);
    check("t4_done_early", done, 0);
    check("t4_trig_ptr", trig_ptr, 9);
    send(23, 1);
    check("t4_done", done, 1);
    readout(10);

    // Reset while ARMED with sample_ce every cycle, including a read in flight.
    do_arm();
    sample_ce = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample_in = DW'(k);
      tick();
    end
    check("t5_armed", state, 2);
    rd_req = 1'b1;
    reset  = 1'b1;
    tick();
    rd_req = 1'b0;
    reset  = 1'b0;
    check("t5_state", state, 0);
    check("t5_done", done, 0);
    check("t5_rd_valid", rd_valid, 0);
    repeat (5) tick();
    check("t5_idle_hold", state, 0);
    sample_ce = 1'b0;
    tick();

    // Abort after 13 samples so the next capture starts at wptr 13 and wraps.
    do_arm();
    for (int k = 0; k < 13; k++) send(-5, 0);
    check("t6_armed_const", state, 2);
    do_arm();
    for (int k = 0; k < 32; k++) begin
      send(k - 20, 0);
      if (k == 20) begin
        check("t6_post", state, 3);
        check("t6_trig_ptr", trig_ptr, 1);
      end
    end
    check("t6_done", done, 1);
    readout(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
